kbd_scan_decoder: RTL and testbench

//  Sequential PS/2 set-2 scan-code decoder: consumes byte strobes from the PS/2 receiver, tracks
//  E0/F0 prefixes and shift state, translates make codes to ASCII/control codes, and buffers

---
 rtl/kbd_scan_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_kbd_scan_decoder.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_scan_decoder.sv
// PS/2 set-2 scan-code decoder: prefix FSM, shift/caps tracking, code translation and FWFT output FIFO.
// Caps-lock handling is compiled in only when KBD_CAPSLOCK_EN is defined.
module kbd_scan_decoder #(
  parameter int FIFO_DEPTH      = 16,
  parameter int REPEAT_SUPPRESS = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  scan_code,
  input  logic                        scan_valid,
  output logic [7:0]                  ascii_code,
  output logic                        ascii_valid,
  input  logic                        ascii_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        shift_state,
  output logic                        caps_state,
  output logic                        overflow,
  input  logic                        overflow_clr
);
  // state   | meaning
  // IDLE    | waiting for a make code or a prefix byte
  // EXT     | E0 seen, next byte is an extended make or F0
  // BRK     | F0 seen, next byte is the released key
  // EXT_BRK | E0 F0 seen, next byte is the released extended key
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);

  state_t      state, state_nxt;
  logic        shift_l, shift_r, caps;
  logic        shift_l_nxt, shift_r_nxt, caps_nxt;
  logic [8:0]  held, held_nxt;
  logic        do_make, do_brk, key_ext, emit;
  logic        is_ack, is_shift_code;
  logic [7:0]  xlated;
  logic        pipe_valid;
  logic [7:0]  pipe_data;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        full, push, pop;

  function automatic logic [7:0] xlate(input logic [7:0] code, input logic shf, input logic cap);
    logic [7:0] lo;
    logic [7:0] hi;
    logic       letter;
    lo = 8'h00;
    hi = 8'h00;
    case (code)
      8'h1C: lo = "a";   8'h32: lo = "b";   8'h21: lo = "c";   8'h23: lo = "d";
      8'h24: lo = "e";   8'h2B: lo = "f";   8'h34: lo = "g";   8'h33: lo = "h";
      8'h43: lo = "i";   8'h3B: lo = "j";   8'h42: lo = "k";   8'h4B: lo = "l";
      8'h3A: lo = "m";   8'h31: lo = "n";   8'h44: lo = "o";   8'h4D: lo = "p";
      8'h15: lo = "q";   8'h2D: lo = "r";   8'h1B: lo = "s";   8'h2C: lo = "t";
      8'h3C: lo = "u";   8'h2A: lo = "v";   8'h1D: lo = "w";   8'h22: lo = "x";
      8'h35: lo = "y";   8'h1A: lo = "z";
      8'h45: begin lo = "0"; hi = ")"; end
      8'h16: begin lo = "1"; hi = "!"; end
      8'h1E: begin lo = "2"; hi = "@"; end
      8'h26: begin lo = "3"; hi = "#"; end
      8'h25: begin lo = "4"; hi = "$"; end
      8'h2E: begin lo = "5"; hi = "%"; end
      8'h36: begin lo = "6"; hi = "^"; end
      8'h3D: begin lo = "7"; hi = "&"; end
      8'h3E: begin lo = "8"; hi = "*"; end
      8'h46: begin lo = "9"; hi = "("; end
      8'h0E: begin lo = 8'h60; hi = 8'h7E; end
      8'h4E: begin lo = "-"; hi = "_"; end
      8'h55: begin lo = "="; hi = "+"; end
      8'h54: begin lo = "["; hi = "{"; end
      8'h5B: begin lo = "]"; hi = "}"; end
      8'h5D: begin lo = 8'h5C; hi = "|"; end
      8'h4C: begin lo = ";"; hi = ":"; end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h41: begin lo = ","; hi = "<"; end
      8'h49: begin lo = "."; hi = ">"; end
      8'h4A: begin lo = "/"; hi = "?"; end
      8'h29: lo = 8'h20;  8'h5A: lo = 8'h0D;  8'h66: lo = 8'h08;  8'h0D: lo = 8'h09;
      8'h76: lo = 8'h1B;  8'h6C: lo = 8'h02;  8'h69: lo = 8'h03;  8'h75: lo = 8'h12;
      8'h72: lo = 8'h11;  8'h6B: lo = 8'h13;  8'h74: lo = 8'h14;  8'h7D: lo = 8'h01;
      8'h7A: lo = 8'h04;  8'h71: lo = 8'h18;
      default: lo = 8'h00;
    endcase
    letter = (lo >= "a") && (lo <= "z");
    if (letter)
      hi = lo - 8'h20;
    else if (hi == 8'h00)
      hi = lo;
    return (letter ? (shf ^ cap) : shf) ? hi : lo;
  endfunction

  assign is_ack        = scan_code inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE};
  assign is_shift_code = (scan_code == 8'h12) || (scan_code == 8'h59);
  assign xlated        = xlate(scan_code, shift_l | shift_r, caps);

  always_comb begin
    state_nxt   = state;
    do_make     = 1'b0;
    do_brk      = 1'b0;
    key_ext     = 1'b0;
    emit        = 1'b0;
    shift_l_nxt = shift_l;
    shift_r_nxt = shift_r;
    caps_nxt    = caps;
    held_nxt    = held;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (scan_code == 8'hE0)      state_nxt = EXT;
          else if (scan_code == 8'hF0) state_nxt = BRK;
          else if (!is_ack)            do_make = 1'b1;
        end
        EXT: begin
          if (scan_code == 8'hF0) state_nxt = EXT_BRK;
          else begin
            do_make   = 1'b1;
            key_ext   = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          do_brk    = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          do_brk    = 1'b1;
          key_ext   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    // Extended 12/59 are the keyboard's fake shifts and never touch shift or held-key state.
    if (do_make) begin
      if (is_shift_code) begin
        if (!key_ext) begin
          if (scan_code == 8'h12) shift_l_nxt = 1'b1;
          else                    shift_r_nxt = 1'b1;
        end
      end else if (!((REPEAT_SUPPRESS != 0) && (held == {key_ext, scan_code}))) begin
        held_nxt = {key_ext, scan_code};
`ifdef KBD_CAPSLOCK_EN
        if (!key_ext && (scan_code == 8'h58)) caps_nxt = ~caps;
        else                                  emit = 1'b1;
`else
        emit = 1'b1;
`endif
      end
    end
    if (do_brk) begin
      if (is_shift_code) begin
        if (!key_ext) begin
          if (scan_code == 8'h12) shift_l_nxt = 1'b0;
          else                    shift_r_nxt = 1'b0;
        end
      end else if (held == {key_ext, scan_code}) begin
        held_nxt = 9'h000;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_l    <= 1'b0;
      shift_r    <= 1'b0;
      caps       <= 1'b0;
      held       <= 9'h000;
      pipe_valid <= 1'b0;
      pipe_data  <= 8'h00;
    end else begin
      state      <= state_nxt;
      shift_l    <= shift_l_nxt;
      shift_r    <= shift_r_nxt;
      caps       <= caps_nxt;
      held       <= held_nxt;
      pipe_valid <= emit && (xlated != 8'h00);
      pipe_data  <= xlated;
    end
  end

  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop  = ascii_valid && ascii_ready;
  assign push = pipe_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pipe_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (pipe_valid && full && !pop) overflow <= 1'b1;
      else if (overflow_clr)          overflow <= 1'b0;
    end
  end

  assign ascii_valid = (count != '0);
  assign ascii_code  = ascii_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count  = count;
  assign shift_state = shift_l | shift_r;
  assign caps_state  = caps;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Scoreboard bench for kbd_scan_decoder: two instances (depth 16 / no suppression, depth 4 / repeat
// suppression) share one byte stream; a key-event reference model predicts each instance's output.
module tb_kbd_scan_decoder;
  localparam int D0 = 16;
  localparam int D1 = 4;
  localparam int RS [2] = '{0, 1};
`ifdef KBD_CAPSLOCK_EN
  localparam bit CAPS_EN = 1'b1;
`else
  localparam bit CAPS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       ready0 = 1'b0, ready1 = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] code0, code1;
  logic       valid0, valid1, shift0, shift1, caps0, caps1, ovf0, ovf1;
  logic [4:0] cnt0;
  logic [2:0] cnt1;

  always #5 clk = ~clk;

  kbd_scan_decoder #(.FIFO_DEPTH(D0), .REPEAT_SUPPRESS(0)) dut0 (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .ascii_code(code0), .ascii_valid(valid0), .ascii_ready(ready0), .fifo_count(cnt0),
    .shift_state(shift0), .caps_state(caps0), .overflow(ovf0), .overflow_clr(ovf_clr));

  kbd_scan_decoder #(.FIFO_DEPTH(D1), .REPEAT_SUPPRESS(1)) dut1 (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .ascii_code(code1), .ascii_valid(valid1), .ascii_ready(ready1), .fifo_count(cnt1),
    .shift_state(shift1), .caps_state(caps1), .overflow(ovf1), .overflow_clr(ovf_clr));

  int checks = 0;
  int failures = 0;
  logic [7:0] q0[$], q1[$];
  bit hold0 = 0, hold1 = 0, force0 = 0, force1 = 0;
  bit ovf_phase = 0;
  int n_in1 = 0;

  localparam logic [7:0] LET_C [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG_C [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46};
  localparam logic [7:0] PUN_C [10] = '{8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41,
    8'h49, 8'h4A};
  localparam logic [7:0] PUN_LO [10] = '{8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C,
    8'h2E, 8'h2F};
  localparam logic [7:0] PUN_HI [10] = '{8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C,
    8'h3E, 8'h3F};
  localparam logic [7:0] SPC_C [14] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h6C, 8'h69, 8'h75,
    8'h72, 8'h6B, 8'h74, 8'h7D, 8'h7A, 8'h71};
  localparam logic [7:0] SPC_V [14] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B, 8'h02, 8'h03, 8'h12,
    8'h11, 8'h13, 8'h14, 8'h01, 8'h04, 8'h18};
  localparam logic [7:0] ACK_C [5] = '{8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE};

  bit [7:0] lo_t [256];
  bit [7:0] hi_t [256];
  bit       let_t [256];
  logic [8:0] pool[$];

  bit m_ext [2], m_brk [2], m_lsh [2], m_rsh [2], m_caps [2];
  logic [8:0] m_held [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic init_tables();
    string s_let, s_dig;
    s_let = "abcdefghijklmnopqrstuvwxyz";
    s_dig = ")!@#$%^&*(";
    for (int i = 0; i < 26; i++) begin
      lo_t[LET_C[i]] = s_let[i];
      hi_t[LET_C[i]] = s_let[i] - 8'd32;
      let_t[LET_C[i]] = 1'b1;
      pool.push_back({1'b0, LET_C[i]});
    end
    for (int i = 0; i < 10; i++) begin
      lo_t[DIG_C[i]] = 8'h30 + 8'(i);
      hi_t[DIG_C[i]] = s_dig[i];
      pool.push_back({1'b0, DIG_C[i]});
      lo_t[PUN_C[i]] = PUN_LO[i];
      hi_t[PUN_C[i]] = PUN_HI[i];
      pool.push_back({1'b0, PUN_C[i]});
    end
    lo_t[8'h0E] = 8'h60;
    hi_t[8'h0E] = 8'h7E;
    for (int i = 0; i < 14; i++) begin
      lo_t[SPC_C[i]] = SPC_V[i];
      hi_t[SPC_C[i]] = SPC_V[i];
      pool.push_back({1'b0, SPC_C[i]});
      if (i >= 5) pool.push_back({1'b1, SPC_C[i]});
    end
    pool.push_back(9'h15A); pool.push_back(9'h14A); pool.push_back(9'h00E);
    pool.push_back(9'h012); pool.push_back(9'h059); pool.push_back(9'h058);
    pool.push_back(9'h112); pool.push_back(9'h159); pool.push_back(9'h005);
    pool.push_back(9'h014); pool.push_back(9'h077);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ext[i] = 0; m_brk[i] = 0; m_lsh[i] = 0; m_rsh[i] = 0; m_caps[i] = 0;
      m_held[i] = 9'h000;
    end
  endfunction

  function automatic int model_make(int i, bit e, logic [7:0] c);
    bit up;
    if (c == 8'h12 || c == 8'h59) begin
      if (!e) begin
        if (c == 8'h12) m_lsh[i] = 1; else m_rsh[i] = 1;
      end
      return -1;
    end
    if (RS[i] != 0 && m_held[i] == {e, c}) return -1;
    m_held[i] = {e, c};
    if (CAPS_EN && !e && c == 8'h58) begin
      m_caps[i] = !m_caps[i];
      return -1;
    end
    up = let_t[c] ? ((m_lsh[i] | m_rsh[i]) ^ m_caps[i]) : (m_lsh[i] | m_rsh[i]);
    if ((up ? hi_t[c] : lo_t[c]) == 8'h00) return -1;
    return int'(up ? hi_t[c] : lo_t[c]);
  endfunction

  function automatic void model_break(int i, bit e, logic [7:0] c);
    if (c == 8'h12 || c == 8'h59) begin
      if (!e) begin
        if (c == 8'h12) m_lsh[i] = 0; else m_rsh[i] = 0;
      end
    end else if (m_held[i] == {e, c}) begin
      m_held[i] = 9'h000;
    end
  endfunction

  function automatic int model_byte(int i, logic [7:0] b);
    int r;
    r = -1;
    if (m_brk[i]) begin
      model_break(i, m_ext[i], b);
      m_ext[i] = 0;
      m_brk[i] = 0;
    end else if (b == 8'hF0) begin
      m_brk[i] = 1;
    end else if (m_ext[i]) begin
      r = model_make(i, 1'b1, b);
      m_ext[i] = 0;
    end else if (b == 8'hE0) begin
      m_ext[i] = 1;
    end else if (!(b inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE})) begin
      r = model_make(i, 1'b0, b);
    end
    return r;
  endfunction

  task automatic predict(logic [7:0] b);
    int r;
    r = model_byte(0, b);
    if (r >= 0) q0.push_back(r[7:0]);
    r = model_byte(1, b);
    if (r >= 0) begin
      if (ovf_phase && n_in1 >= D1) begin
        // dropped by a full FIFO with no pop
      end else begin
        q1.push_back(r[7:0]);
        if (ovf_phase) n_in1++;
      end
    end
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic send_byte(logic [7:0] b, int gap);
    predict(b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_flags(string tag);
    check({tag, "_shift0"}, shift0, m_lsh[0] | m_rsh[0]);
    check({tag, "_shift1"}, shift1, m_lsh[1] | m_rsh[1]);
    check({tag, "_caps0"}, caps0, m_caps[0]);
    check({tag, "_caps1"}, caps1, m_caps[1]);
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL %s_drain_timeout left0=%0d left1=%0d required=0", tag, q0.size(), q1.size());
    end
    repeat (3) @(negedge clk);
    check({tag, "_idle_valid0"}, valid0, 1'b0);
    check({tag, "_idle_valid1"}, valid1, 1'b0);
  endtask

  initial forever begin
    @(negedge clk);
    ready0 = hold0 ? force0 : ((cnt0 >= D0 - 1) ? 1'b1 : ($urandom_range(0, 2) != 0));
    ready1 = hold1 ? force1 : ((cnt1 >= D1 - 1) ? 1'b1 : ($urandom_range(0, 2) != 0));
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (!reset && valid0 && ready0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut0_unexpected actual=%0h expected=none", code0);
      end else check("dut0_data", code0, q0.pop_front());
    end
    if (!reset && valid1 && ready1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_unexpected actual=%0h expected=none", code1);
      end else check("dut1_data", code1, q1.pop_front());
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] k, last;
    int r;
    init_tables();
    model_reset();
    last = 9'h01C;
    repeat (3) @(negedge clk);
    check("rst_valid0", valid0, 1'b0);
    check("rst_count0", cnt0, 0);
    check("rst_code0", code0, 8'h00);
    check("rst_count1", cnt1, 0);
    check("rst_ovf0", ovf0, 1'b0);
    check_flags("rst");
    reset = 1'b0;
    @(negedge clk);

    // Latency: make 1C, nothing popped.
    hold0 = 1; hold1 = 1;
    @(negedge clk); @(negedge clk);
    send_byte(8'h1C, 0);
    check("lat_n1_valid0", valid0, 1'b0);
    check("lat_n1_code0", code0, 8'h00);
    @(negedge clk);
    check("lat_n2_valid0", valid0, 1'b1);
    check("lat_n2_code0", code0, 8'h61);
    check("lat_n2_count0", cnt0, 1);
    check("lat_n2_count1", cnt1, 1);
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 2);
    check("lat_after_brk_count0", cnt0, 1);
    hold0 = 0; hold1 = 0;
    drain("t1");

    // Shift handling.
    send_byte(8'h12, 0);
    check("t2_shift_on", shift0, 1'b1);
    send_byte(8'h1C, 0); send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    send_byte(8'hF0, 0); send_byte(8'h12, 0);
    check("t2_shift_off", shift0, 1'b0);
    send_byte(8'h1C, 1);
    check_flags("t2");
    drain("t2");

    // Caps-lock, shifted digit.
    send_byte(8'h58, 0);
    check("t3_caps_set", caps0, CAPS_EN);
    send_byte(8'h1C, 0); send_byte(8'h12, 0); send_byte(8'h16, 0);
    check_flags("t3a");
    send_byte(8'hF0, 0); send_byte(8'h12, 0); send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    send_byte(8'hF0, 0); send_byte(8'h16, 0); send_byte(8'hF0, 0); send_byte(8'h58, 0);
    send_byte(8'h58, 0); send_byte(8'hF0, 0); send_byte(8'h58, 1);
    check("t3_caps_clear", caps0, 1'b0);
    check_flags("t3b");
    drain("t3");

    // Extended keys and fake shift.
    send_byte(8'hE0, 0); send_byte(8'h75, 0);
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
    send_byte(8'hE0, 0); send_byte(8'h12, 1);
    check("t4_fake_shift", shift0, 1'b0);
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h12, 1);
    check_flags("t4");
    drain("t4");

    // Overflow on the depth-4 instance.
    hold1 = 1; force1 = 0;
    @(negedge clk); @(negedge clk);
    ovf_phase = 1; n_in1 = 0;
    repeat (5) begin
      send_byte(8'h16, 0); send_byte(8'hF0, 0); send_byte(8'h16, 1);
    end
    ovf_phase = 0;
    repeat (3) @(negedge clk);
    check("t5_full_count1", cnt1, 4);
    check("t5_ovf1_set", ovf1, 1'b1);
    check("t5_ovf0_clear", ovf0, 1'b0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t5_ovf1_cleared", ovf1, 1'b0);
    predict(8'h1C);
    scan_code = 8'h1C;
    scan_valid = 1'b1;
    #2 force1 = 1;
    @(negedge clk);
    scan_valid = 1'b0;
    #2 force1 = 0;
    @(negedge clk);
    check("t5_pushpop_count1", cnt1, 4);
    check("t5_pushpop_ovf1", ovf1, 1'b0);
    hold1 = 0;
    send_byte(8'hF0, 0); send_byte(8'h1C, 1);
    drain("t5");

    // Repeat suppression, then reset in the middle of an E0 prefix.
    send_byte(8'h1C, 0); send_byte(8'h1C, 0); send_byte(8'h1C, 0);
    send_byte(8'hF0, 0); send_byte(8'h1C, 0); send_byte(8'h1C, 1);
    send_byte(8'hF0, 0); send_byte(8'h1C, 1);
    drain("t6");
    send_byte(8'hE0, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("t6_rst_count0", cnt0, 0);
    check("t6_rst_count1", cnt1, 0);
    check("t6_rst_valid1", valid1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    send_byte(8'h12, 0); send_byte(8'h1C, 0);
    check_flags("t6");
    send_byte(8'hF0, 0); send_byte(8'h1C, 0); send_byte(8'hF0, 0); send_byte(8'h12, 1);
    drain("t6b");

    // Randomized key traffic.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        send_byte(ACK_C[$urandom_range(0, 4)], $urandom_range(0, 2));
      end else begin
        k = (r < 30) ? last : pool[$urandom_range(0, pool.size() - 1)];
        last = k;
        if (k[8]) send_byte(8'hE0, $urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) send_byte(8'hF0, $urandom_range(0, 1));
        send_byte(k[7:0], $urandom_range(0, 2));
      end
      if (n % 50 == 49) check_flags("rand");
    end
    drain("rand");
    check("end_ovf0", ovf0, 1'b0);
    check("end_ovf1", ovf1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
